// File: rtl/rgb24_unpack_pkg.sv
// Shared types and constants for the RGB24 word unpacker.
package rgb24_unpack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int BYTES_PER_WORD = 8;
  localparam int BYTES_PER_PIX  = 3;
  localparam int BUF_BYTES      = 16;

  // Number of 64-bit words holding n packed 24-bit pixels: ceil(3n/8).
  function automatic logic [31:0] ceil_words(input logic [31:0] n);
    logic [31:0] nbytes;
    nbytes = n * 32'(BYTES_PER_PIX);
    return (nbytes + 32'(BYTES_PER_WORD - 1)) >> 3;
  endfunction

endpackage

// File: rtl/rgb24_word_unpacker.sv
// Realigns 64-bit little-endian words of one RGB24 line into one {r,g,b}
// pixel per handshake. A 16-byte buffer is drained 3 bytes at a time from the
// low end and refilled 8 bytes at a time at the current fill level.
module rgb24_word_unpacker
  import rgb24_unpack_pkg::*;
#(
  parameter int NPIX_W = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [NPIX_W-1:0] npix,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  input  logic [63:0]       in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [23:0]       out_data,
  output logic              out_last,
  input  logic              out_ready
);

  state_e                        state;
  logic [BUF_BYTES-1:0][7:0]     byte_buf;
  logic [BUF_BYTES-1:0][7:0]     buf_d;
  logic [BUF_BYTES-1:0][7:0]     shifted;
  logic [4:0]                    cnt;
  logic [4:0]                    cnt_d;
  logic [4:0]                    base;
  logic [NPIX_W-1:0]             pix_rem;
  logic [NPIX_W-1:0]             word_rem;
  logic                          accept;
  logic                          pix_hs;

  // Handshakes and status are decoded from registered state only, so there
  // is no combinational path from the input word to the pixel output.
  assign in_ready  = (state == RUN) && (cnt <= 5'd8) && (word_rem != '0);
  assign out_valid = (state == RUN) && (cnt >= 5'd3) && (pix_rem != '0);
  assign out_data  = {byte_buf[2], byte_buf[1], byte_buf[0]};
  assign out_last  = out_valid && (pix_rem == NPIX_W'(1));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign pix_hs    = out_valid && out_ready;

  // Next buffer: drop the consumed pixel first, then drop the new word in
  // at the resulting fill level (never above byte 8, so it always fits).
  always_comb begin
    shifted = pix_hs ? (byte_buf >> (8 * BYTES_PER_PIX)) : byte_buf;
    base    = pix_hs ? (cnt - 5'd3) : cnt;
    buf_d   = shifted;
    cnt_d   = base;
    if (accept) begin
      for (int k = 0; k < BYTES_PER_WORD; k++)
        buf_d[base[3:0] + 4'(k)] = in_data[8*k +: 8];
      cnt_d = base + 5'd8;
    end
  end

  // Line control FSM and buffer/counter state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      byte_buf <= '0;
      cnt      <= '0;
      pix_rem  <= '0;
      word_rem <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (npix != '0) begin
              pix_rem  <= npix;
              word_rem <= NPIX_W'(ceil_words(32'(npix)));
              byte_buf <= '0;
              cnt      <= '0;
              state    <= RUN;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          byte_buf <= buf_d;
          cnt      <= cnt_d;
          if (accept) word_rem <= word_rem - NPIX_W'(1);
          if (pix_hs) pix_rem <= pix_rem - NPIX_W'(1);
          // Final pixel: leftover pad bytes are simply forgotten.
          if (pix_hs && (pix_rem == NPIX_W'(1))) begin
            cnt   <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb24_word_unpacker.sv
// Randomized bench for rgb24_word_unpacker with a byte-stream reference model.
module tb_rgb24_word_unpacker;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [15:0] npix = '0;
  logic        busy, done;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [23:0] out_data;
  logic        out_last;
  logic        out_ready = 1'b0;

  rgb24_word_unpacker #(.NPIX_W(16)) dut (
    .clock(clock), .resetn(resetn), .start(start), .npix(npix),
    .busy(busy), .done(done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference state: pending source words, expected {last,pixel} stream,
  // pixels observed, and the line-level phase (0 idle, 1 run, 2 done).
  logic [63:0] wq[$];
  logic [24:0] epq[$];
  logic [23:0] got[$];
  int  mstate = 0;
  int  words_acc = 0;
  int  exp_words = 0;
  int  lines_done = 0;
  bit  word_taken = 0;
  bit  prev_stall = 0;
  logic [23:0] prev_data = '0;
  int  valid_pct = 100;
  int  ready_pct = 100;
  bit  force_stall = 0;

  // Source/sink driver: a word stays offered until it is taken.
  initial forever begin
    @(posedge clock); #1;
    if (!resetn) begin
      wq.delete();
      in_valid = 1'b0;
    end else begin
      if (in_valid && word_taken) begin
        void'(wq.pop_front());
        in_valid = 1'b0;
      end
      if (!in_valid && wq.size() > 0 && $urandom_range(99) < valid_pct) begin
        in_valid = 1'b1;
        in_data  = wq[0];
      end
    end
    out_ready = force_stall ? 1'b0 : ($urandom_range(99) < ready_pct);
  end

  // Compare process: outputs sampled mid-cycle, handshakes decided here.
  logic [24:0] e;
  always @(negedge clock) begin
    if (!resetn) begin
      mstate = 0;
      epq.delete();
      word_taken = 0;
      prev_stall = 0;
    end else begin
      chk("busy", busy, mstate != 0);
      chk("done", done, mstate == 2);
      if (mstate != 1) begin
        chk("in_ready_not_run", in_ready, 0);
        chk("out_valid_not_run", out_valid, 0);
      end
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      word_taken = in_valid && in_ready;
      if (word_taken) words_acc++;
      case (mstate)
        0: if (start) begin
             if (npix == 0) mstate = 2;
             else begin mstate = 1; words_acc = 0; end
           end
        1: if (out_valid && out_ready) begin
             if (epq.size() == 0) chk("extra_pixel", 1, 0);
             else begin
               e = epq.pop_front();
               chk("pix_data", out_data, e[23:0]);
               chk("pix_last", out_last, e[24]);
               got.push_back(out_data);
               if (e[24]) begin
                 mstate = 2;
                 chk("words_used", words_acc, exp_words);
               end
             end
           end
        default: begin mstate = 0; lines_done++; end
      endcase
    end
  end

  // Build the line from a flat byte stream and pulse start.
  task automatic run_line(input int n, input bit fixed);
    logic [63:0] w[$];
    int nw;
    logic [23:0] px;
    nw = (3 * n + 7) / 8;
    for (int i = 0; i < nw; i++) begin
      logic [63:0] word;
      if (fixed) for (int k = 0; k < 8; k++) word[8*k +: 8] = 8'(8 * i + k);
      else word = {$urandom, $urandom};
      w.push_back(word);
    end
    got.delete();
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < 3; c++) begin
        int j;
        j = 3 * p + c;
        px[8*c +: 8] = w[j / 8][8 * (j % 8) +: 8];
      end
      epq.push_back({p == n - 1, px});
    end
    exp_words = nw;
    foreach (w[i]) wq.push_back(w[i]);
    @(posedge clock); #2;
    start = 1'b1;
    npix  = 16'(n);
    @(posedge clock); #2;
    start = 1'b0;
    npix  = 16'($urandom);
  endtask

  task automatic wait_done(input string name);
    int l0;
    bit ok;
    l0 = lines_done;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clock);
      ok = (lines_done != l0);
    end
    chk(name, ok, 1);
  endtask

  task automatic wait_pix(input int k);
    bit ok;
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge clock); #2;
      ok = (got.size() >= k);
    end
    chk("wait_pix_timeout", ok, 1);
  endtask

  task automatic check_ramp_line(input string tag);
    chk({tag, "_count"}, got.size(), 8);
    chk({tag, "_px0"}, got[0], 24'h020100);
    chk({tag, "_px2"}, got[2], 24'h080706);
    chk({tag, "_px7"}, got[7], 24'h171615);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_data"}, out_data, 0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 check_all_zero("reset");
    @(posedge clock); #2 resetn = 1'b1;
    repeat (2) @(posedge clock);

    // Ramp line spanning word boundaries, full throughput.
    run_line(8, 1);
    wait_done("ramp_timeout");
    check_ramp_line("ramp");

    // Short line with pad bytes, throttled source and sink.
    valid_pct = 60; ready_pct = 60;
    run_line(3, 0);
    wait_done("short_timeout");
    chk("short_count", got.size(), 3);

    // Sink stall mid-line: buffer fills, source is back-pressured.
    valid_pct = 100; ready_pct = 100;
    run_line(24, 0);
    wait_pix(4);
    force_stall = 1;
    repeat (10) @(posedge clock);
    #3;
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    force_stall = 0;
    wait_done("stall_timeout");
    chk("stall_count", got.size(), 24);

    // Empty line.
    run_line(0, 0);
    wait_done("empty_timeout");
    chk("empty_count", got.size(), 0);

    // Reset in the middle of a line, then the ramp again.
    run_line(8, 1);
    wait_pix(2);
    resetn = 1'b0;
    #1 check_all_zero("midreset");
    @(posedge clock); #2 resetn = 1'b1;
    repeat (3) @(posedge clock);
    run_line(8, 1);
    wait_done("rerun_timeout");
    check_ramp_line("rerun");

    // start during RUN must be ignored.
    ready_pct = 70;
    run_line(8, 1);
    wait_pix(2);
    @(posedge clock); #2 start = 1'b1; npix = 16'd5;
    @(posedge clock); #2 start = 1'b0;
    wait_done("restart_timeout");
    check_ramp_line("restart");

    // Random lines at random rates.
    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(1, 40);
      valid_pct = $urandom_range(30, 100);
      ready_pct = $urandom_range(30, 100);
      run_line(n, 0);
      wait_done("rand_timeout");
      chk("rand_count", got.size(), n);
    end

    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
